// File: rtl/ss_uart_dumper.sv
// Streams the shared-secret buffer to a UART sender: header byte, then every word LSB byte first.
// Optional XOR checksum trailer when DUMP_CHECKSUM_EN is defined.
module ss_uart_dumper #(
  parameter int unsigned NWORDS   = 8,
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned ADDR_W   = 3,
  parameter logic [7:0]  HDR_BYTE = 8'h53
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce,
  input  logic [WORD_W-1:0] mem_q,
  output logic              send_en,
  output logic [7:0]        send_data,
  input  logic              tx_busy
);

  localparam int unsigned NBYTES = WORD_W / 8;
  localparam int unsigned BIDX_W = $clog2(NBYTES + 1);
  localparam logic [BIDX_W-1:0] LastBidx = BIDX_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] LastWidx = ADDR_W'(NWORDS - 1);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StHdr, StFetch, StLatch, StByte, StGap, StCsum, StFin
  } state_t;
`else
  typedef enum logic [2:0] {
    StIdle, StHdr, StFetch, StLatch, StByte, StGap, StFin
  } state_t;
`endif

  state_t              state_q, state_d;
  // Where GAP goes next; decided when the byte is issued so GAP itself is a plain 1-cycle wait.
  state_t              ret_q, ret_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [7:0]          send_data_q;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    widx_d    = widx_q;
    bidx_d    = bidx_q;
    shreg_d   = shreg_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    send_en   = 1'b0;
    send_data = send_data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHdr;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StHdr: begin
        if (!tx_busy) begin
          send_en   = 1'b1;
          send_data = HDR_BYTE;
          widx_d    = '0;
          ret_d     = StFetch;
          state_d   = StGap;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        shreg_d = mem_q;
        bidx_d  = '0;
        state_d = StByte;
      end
      StByte: begin
        if (!tx_busy) begin
          send_en   = 1'b1;
          send_data = shreg_q[7:0];
          shreg_d   = shreg_q >> 8;
          bidx_d    = bidx_q + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          csum_d    = csum_q ^ shreg_q[7:0];
`endif
          state_d   = StGap;
          if (bidx_q != LastBidx) begin
            ret_d = StByte;
          end else if (widx_q != LastWidx) begin
            ret_d  = StFetch;
            widx_d = widx_q + 1'b1;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            ret_d = StCsum;
`else
            ret_d = StFin;
`endif
          end
        end
      end
      StGap: state_d = ret_q;
`ifdef DUMP_CHECKSUM_EN
      StCsum: begin
        if (!tx_busy) begin
          send_en   = 1'b1;
          send_data = csum_q;
          ret_d     = StFin;
          state_d   = StGap;
        end
      end
`endif
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      widx_q      <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      send_data_q <= 8'h00;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      send_data_q <= send_data;
`ifdef DUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);
  assign mem_ce   = (state_q == StFetch);
  assign mem_addr = mem_ce ? widx_q : '0;

endmodule

// File: tb/tb_ss_uart_dumper.sv
// Randomized bench for ss_uart_dumper: frame-level model (expected byte/address queues) checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_ss_uart_dumper;

  localparam int NWORDS = 8;
  localparam int WORD_W = 64;
  localparam int ADDR_W = 3;
`ifdef DUMP_CHECKSUM_EN
  localparam int FL = 66;
`else
  localparam int FL = 65;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              tx_busy = 1'b0;
  logic              busy, done, mem_ce, send_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_q;
  logic [7:0]        send_data;

  logic [WORD_W-1:0] mem [NWORDS];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] log_q[$];
  int         ce_log[$];
  logic [7:0] exp_q[$];
  int         addr_q[$];

  bit         m_busy = 0;
  bit         m_was_busy;
  int         m_cd = -1;
  bit         emptied;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_sum;
  bit         prev_en = 0;
  bit         prev_ce = 0;
  int         busy_cnt = 0;
  int         hold_min = 0;
  int         hold_max = 0;
  int         n_done = 0;

  ss_uart_dumper #(
    .NWORDS  (NWORDS),
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .HDR_BYTE(8'h53)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_ce   (mem_ce),
    .mem_q    (mem_q),
    .send_en  (send_en),
    .send_data(send_data),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ce) mem_q <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor, frame model and uart_sender busy model.
  initial forever begin
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("done", done, m_cd == 0);
    emptied = 0;
    if (send_en) begin
      chk("send_en_spacing", prev_en, 0);
      chk("send_en_while_tx_busy", tx_busy, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h, no byte expected", send_data);
      end else begin
        chk("send_data", send_data, exp_q.pop_front());
        emptied = (exp_q.size() == 0);
      end
      log_q.push_back(send_data);
      m_last = send_data;
      busy_cnt = $urandom_range(hold_max, hold_min);
    end else begin
      chk("send_data_hold", send_data, m_last);
    end
    if (mem_ce) begin
      chk("mem_ce_single", prev_ce, 0);
      ce_log.push_back(int'(mem_addr));
      if (addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got addr %0d, no read expected", mem_addr);
      end else begin
        chk("mem_addr", mem_addr, addr_q.pop_front());
      end
    end
    if (done) begin
      n_done++;
      chk("reads_complete", addr_q.size(), 0);
    end
    prev_en = send_en;
    prev_ce = mem_ce;
    if (rst) begin
      m_busy = 0;
      exp_q.delete();
      addr_q.delete();
      m_cd = -1;
      m_last = 8'h00;
      prev_en = 0;
      prev_ce = 0;
    end else begin
      m_was_busy = m_busy;
      if (m_cd == 0) m_busy = 0;
      if (m_cd >= 0) m_cd--;
      if (emptied) m_cd = 1;
      if (!m_was_busy && start) begin
        m_busy = 1;
        m_sum = 8'h00;
        exp_q.push_back(8'h53);
        for (int w = 0; w < NWORDS; w++) begin
          addr_q.push_back(w);
          for (int b = 0; b < WORD_W / 8; b++) begin
            exp_q.push_back(mem[w][8*b +: 8]);
            m_sum ^= mem[w][8*b +: 8];
          end
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(m_sum);
`endif
      end
    end
    @(posedge clk);
    #1;
    tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  d0;
    bit  ok;
    d0 = n_done;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (n_done > d0) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_timeout: done %0d, expected %0d within %0d cycles", n_done, d0 + 1,
               budget);
    end
    cyc(2);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (log_q.size() >= n) begin
        ok = 1;
        break;
      end
      cyc(1);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL byte_timeout: got %0d bytes, expected %0d", log_q.size(), n);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NWORDS; i++)
      mem[i] = 64'h0706050403020100 + 64'(i) * 64'h0808080808080808;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_send_en"}, send_en, 0);
    chk({tag, "_mem_ce"}, mem_ce, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_send_data"}, send_data, 8'h00);
  endtask

  int d0;

  initial begin
    fill_pattern();
    cyc(3);
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Counting pattern, sender always ready.
    log_q.delete();
    ce_log.delete();
    d0 = n_done;
    pulse_start();
    wait_done(2000);
    chk("s1_len", log_q.size(), FL);
    chk("s1_hdr", log_q[0], 8'h53);
    chk("s1_first", log_q[1], 8'h00);
    chk("s1_byte9", log_q[9], 8'h08);
    chk("s1_last_payload", log_q[64], 8'h3F);
`ifdef DUMP_CHECKSUM_EN
    chk("s1_csum", log_q[65], 8'h00);
`endif
    chk("s1_done_count", n_done - d0, 1);
    chk("s6_reads", ce_log.size(), NWORDS);
    for (int i = 0; i < NWORDS; i++) chk("s6_addr_order", ce_log[i], i);
    chk("s1_idle_after", busy, 0);

    // Sparse buffer: checksum trailer equals the only nonzero byte.
    mem[0] = 64'hA5;
    for (int i = 1; i < NWORDS; i++) mem[i] = '0;
    log_q.delete();
    pulse_start();
    wait_done(2000);
    chk("s2_len", log_q.size(), FL);
`ifdef DUMP_CHECKSUM_EN
    chk("s2_trailer", log_q[FL-1], 8'hA5);
`else
    chk("s2_last", log_q[FL-1], 8'h00);
`endif
    chk("s2_first_payload", log_q[1], 8'hA5);

    // Slow sender: 10 busy cycles after every byte.
    fill_pattern();
    hold_min = 10;
    hold_max = 10;
    log_q.delete();
    pulse_start();
    wait_done(3000);
    chk("s3_len", log_q.size(), FL);
    chk("s3_hdr", log_q[0], 8'h53);
    for (int i = 1; i < 65; i++) chk("s3_order", log_q[i], 8'(i - 1));

    // Second start mid-frame is dropped.
    hold_min = 0;
    hold_max = 3;
    log_q.delete();
    d0 = n_done;
    pulse_start();
    wait_bytes(20, 500);
    pulse_start();
    wait_done(2000);
    cyc(30);
    chk("s4_done_count", n_done - d0, 1);
    chk("s4_len", log_q.size(), FL);
    chk("s4_idle", busy, 0);

    // Reset mid-frame, coincident with start, then a clean frame.
    log_q.delete();
    pulse_start();
    wait_bytes(30, 500);
    rst = 1'b1;
    start = 1'b1;
    cyc(1);
    rst = 1'b0;
    start = 1'b0;
    chk_reset_outputs("s5_after_rst");
    cyc(15);
    chk("s5_stays_idle", busy, 0);
    log_q.delete();
    pulse_start();
    wait_done(2000);
    chk("s5_hdr", log_q[0], 8'h53);
    chk("s5_len", log_q.size(), FL);

    // Random buffers, random sender latency, random start pokes while busy.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NWORDS; i++) mem[i] = {$urandom, $urandom};
      hold_min = 0;
      hold_max = $urandom_range(0, 5);
      log_q.delete();
      d0 = n_done;
      pulse_start();
      for (int i = 0; i < 3000 && n_done == d0; i++) begin
        start = ($urandom_range(0, 15) == 0);
        cyc(1);
      end
      start = 1'b0;
      chk("rand_done", n_done - d0, 1);
      cyc(3);
      chk("rand_len", log_q.size(), FL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
